// File: rtl/cdc_sync_filter.sv
// cdc_sync_filter
//   Bank of WIDTH independent asynchronous-input synchronizers into the aclk
//   domain. Each channel runs through a STAGES-deep flop chain, then an
//   optional glitch filter that accepts a new level only after it has held
//   for FILTER consecutive aclk cycles, then registered-history edge detect.
//   Channels are not coherent with each other: never pass multi-bit values.
//
// Ports
//   aclk      in   1      destination clock
//   arstn     in   1      asynchronous active-low reset (released synchronously)
//   data_i    in   WIDTH  asynchronous inputs from any source domain
//   data_o    out  WIDTH  synchronized (and filtered) level
//   rise_o    out  WIDTH  one-cycle pulse on 0->1 of data_o
//   fall_o    out  WIDTH  one-cycle pulse on 1->0 of data_o
//   change_o  out  WIDTH  rise_o | fall_o
module cdc_sync_filter #(
  parameter int unsigned      WIDTH   = 4,
  parameter int unsigned      STAGES  = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  parameter int unsigned      FILTER  = 0
) (
  input  logic             aclk,
  input  logic             arstn,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o,
  output logic [WIDTH-1:0] change_o
);

  if (STAGES < 2) begin : g_bad_stages
    $error("cdc_sync_filter: STAGES must be >= 2");
  end
  if (FILTER > 255) begin : g_bad_filter
    $error("cdc_sync_filter: FILTER must be <= 255");
  end
  if (WIDTH < 1) begin : g_bad_width
    $error("cdc_sync_filter: WIDTH must be >= 1");
  end

  // Synchronizer chain: stage[0] samples the async input, the last stage is s.
  logic [STAGES-1:0][WIDTH-1:0] stage_q;
  logic [WIDTH-1:0]             sync;
  logic [WIDTH-1:0]             filt;
  logic [WIDTH-1:0]             prev_q;

  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      stage_q <= {STAGES{RST_VAL}};
    end else begin
      stage_q <= {stage_q[STAGES-2:0], data_i};
    end
  end

  assign sync = stage_q[STAGES-1];

  if (FILTER == 0) begin : g_bypass
    assign filt = sync;
  end else begin : g_filter
    localparam int unsigned   CW       = (FILTER > 1) ? $clog2(FILTER) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER - 1);

    logic [WIDTH-1:0]         f_q;
    logic [WIDTH-1:0][CW-1:0] cnt_q;

    // cnt counts consecutive cycles of s != f; any agreement restarts it,
    // so a disagreement must persist FILTER cycles to be accepted.
    always_ff @(posedge aclk or negedge arstn) begin
      if (!arstn) begin
        f_q   <= RST_VAL;
        cnt_q <= '0;
      end else begin
        for (int unsigned i = 0; i < WIDTH; i++) begin
          if (sync[i] == f_q[i]) begin
            cnt_q[i] <= '0;
          end else if (cnt_q[i] == CNT_LAST) begin
            f_q[i]   <= sync[i];
            cnt_q[i] <= '0;
          end else begin
            cnt_q[i] <= cnt_q[i] + 1'b1;
          end
        end
      end
    end

    assign filt = f_q;
  end

  // Edge history shares the reset value, so release alone never pulses.
  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      prev_q <= RST_VAL;
    end else begin
      prev_q <= filt;
    end
  end

  assign data_o   = filt;
  assign rise_o   = filt & ~prev_q;
  assign fall_o   = ~filt & prev_q;
  assign change_o = rise_o | fall_o;

endmodule

// File: tb/tb_cdc_sync_filter.sv
module tb_cdc_sync_filter;

  logic aclk = 1'b0;
  always #5 aclk = ~aclk;

  logic       arstn;
  logic [3:0] din_a, dout_a, rise_a, fall_a, chg_a;
  logic [1:0] din_b, dout_b, rise_b, fall_b, chg_b;

  cdc_sync_filter #(
    .WIDTH   (4),
    .STAGES  (2),
    .RST_VAL (4'b0101),
    .FILTER  (3)
  ) u_dut_a (
    .aclk     (aclk),
    .arstn    (arstn),
    .data_i   (din_a),
    .data_o   (dout_a),
    .rise_o   (rise_a),
    .fall_o   (fall_a),
    .change_o (chg_a)
  );

  cdc_sync_filter #(
    .WIDTH   (2),
    .STAGES  (3),
    .RST_VAL (2'b00),
    .FILTER  (0)
  ) u_dut_b (
    .aclk     (aclk),
    .arstn    (arstn),
    .data_i   (din_b),
    .data_o   (dout_b),
    .rise_o   (rise_b),
    .fall_o   (fall_b),
    .change_o (chg_b)
  );

  typedef struct {
    logic [3:0] din_a;
    logic [3:0] dout_a;
    logic [3:0] rise_a;
    logic [3:0] fall_a;
    logic [1:0] din_b;
    logic [1:0] dout_b;
    logic [1:0] rise_b;
    logic [1:0] fall_b;
  } vec_t;

  vec_t        vecs [12];
  vec_t        sb_q [$];
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_a(input string tag, input logic [3:0] d, input logic [3:0] r,
                         input logic [3:0] f);
    check({tag, ".a.data"},   dout_a, d);
    check({tag, ".a.rise"},   rise_a, r);
    check({tag, ".a.fall"},   fall_a, f);
    check({tag, ".a.change"}, chg_a,  r | f);
  endtask

  task automatic check_b(input string tag, input logic [1:0] d, input logic [1:0] r,
                         input logic [1:0] f);
    check({tag, ".b.data"},   {2'b00, dout_b}, {2'b00, d});
    check({tag, ".b.rise"},   {2'b00, rise_b}, {2'b00, r});
    check({tag, ".b.fall"},   {2'b00, fall_b}, {2'b00, f});
    check({tag, ".b.change"}, {2'b00, chg_b},  {2'b00, r | f});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    // Row k: inputs driven just after edge k, outputs expected after edge k.
    // A: bit1 rises (accepted at step 5), bit3 2-cycle glitch (rejected),
    //    bit2 low 2 / high 1 / low held (falls at step 8), bit0 held high.
    // B: 11 for 3 steps (visible at step 3), then a 1-step pulse on bit0.
    vecs[0]  = '{4'b1011, 4'b0101, 4'b0000, 4'b0000, 2'b11, 2'b00, 2'b00, 2'b00};
    vecs[1]  = '{4'b1011, 4'b0101, 4'b0000, 4'b0000, 2'b11, 2'b00, 2'b00, 2'b00};
    vecs[2]  = '{4'b0111, 4'b0101, 4'b0000, 4'b0000, 2'b11, 2'b00, 2'b00, 2'b00};
    vecs[3]  = '{4'b0011, 4'b0101, 4'b0000, 4'b0000, 2'b00, 2'b11, 2'b11, 2'b00};
    vecs[4]  = '{4'b0011, 4'b0101, 4'b0000, 4'b0000, 2'b00, 2'b11, 2'b00, 2'b00};
    vecs[5]  = '{4'b0011, 4'b0111, 4'b0010, 4'b0000, 2'b00, 2'b11, 2'b00, 2'b00};
    vecs[6]  = '{4'b0011, 4'b0111, 4'b0000, 4'b0000, 2'b00, 2'b00, 2'b00, 2'b11};
    vecs[7]  = '{4'b0011, 4'b0111, 4'b0000, 4'b0000, 2'b01, 2'b00, 2'b00, 2'b00};
    vecs[8]  = '{4'b0011, 4'b0011, 4'b0000, 4'b0100, 2'b00, 2'b00, 2'b00, 2'b00};
    vecs[9]  = '{4'b0011, 4'b0011, 4'b0000, 4'b0000, 2'b00, 2'b00, 2'b00, 2'b00};
    vecs[10] = '{4'b0011, 4'b0011, 4'b0000, 4'b0000, 2'b00, 2'b01, 2'b01, 2'b00};
    vecs[11] = '{4'b0011, 4'b0011, 4'b0000, 4'b0000, 2'b00, 2'b00, 2'b00, 2'b01};

    // Reset with inputs at the reset value.
    arstn = 1'b1;
    din_a = 4'b0101;
    din_b = 2'b00;
    #2 arstn = 1'b0;
    #1;
    check_a("rst_async", 4'b0101, 4'b0000, 4'b0000);
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check_a("rst_hold", 4'b0101, 4'b0000, 4'b0000);
    check_b("rst_hold", 2'b00, 2'b00, 2'b00);
    @(posedge aclk);
    #1 arstn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge aclk);
      check_a("idle", 4'b0101, 4'b0000, 4'b0000);
      check_b("idle", 2'b00, 2'b00, 2'b00);
    end

    // Table-driven main sequence through the scoreboard queue.
    for (int i = 0; i < 12; i++) begin
      vec_t e;
      @(posedge aclk);
      #1;
      din_a = vecs[i].din_a;
      din_b = vecs[i].din_b;
      sb_q.push_back(vecs[i]);
      @(negedge aclk);
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL scoreboard: queue empty at step %0d", i);
      end else begin
        e = sb_q.pop_front();
        check_a($sformatf("tbl%0d", i), e.dout_a, e.rise_a, e.fall_a);
        check_b($sformatf("tbl%0d", i), e.dout_b, e.rise_b, e.fall_b);
      end
    end

    // Reset mid-count: bit0 goes low, reset lands when its counter is at 1.
    @(posedge aclk);
    #1 din_a = 4'b0010;
    @(negedge aclk);
    check_a("midrst_s0", 4'b0011, 4'b0000, 4'b0000);
    for (int j = 1; j < 3; j++) begin
      @(negedge aclk);
      check_a($sformatf("midrst_s%0d", j), 4'b0011, 4'b0000, 4'b0000);
    end
    @(posedge aclk);
    #1;
    check_a("midrst_s3", 4'b0011, 4'b0000, 4'b0000);
    arstn = 1'b0;
    #1;
    check_a("midrst_assert", 4'b0101, 4'b0000, 4'b0000);
    din_a = 4'b0101;
    repeat (2) @(posedge aclk);
    #1 arstn = 1'b1;
    for (int j = 0; j < 10; j++) begin
      @(negedge aclk);
      check_a("midrst_post", 4'b0101, 4'b0000, 4'b0000);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cdc_sync_filter.md
Name: cdc_sync_filter

Overview:
Parametrised multi-bit asynchronous-input synchronizer bank and the successor of the 2-flop single-bit synchronizer. Each channel passes through a configurable-depth flop chain into the aclk domain, then an optional per-channel glitch filter. The filter requires the synchronized value to stay stable before it is accepted. Registered-history edge detectors follow the filter. Used for slow control and status signals, such as interrupts, buttons and status lines from foreign domains, where single-cycle glitches must not propagate.

Parameters:
WIDTH, 4, number of independent channels (>=1)
STAGES, 2, synchronizer flops per channel (>=2; elaboration error otherwise)
RST_VAL, {WIDTH{1'b0}}, per-channel reset value of chain, filter state and outputs
FILTER, 0, consecutive aclk cycles a new synchronized value must persist before acceptance; 0 = filter bypassed (max 255)

Ports:
aclk  input  1  destination clock
arstn  input  1  asynchronous active-low reset
data_i  input  WIDTH  asynchronous inputs, any source domain
data_o  output  WIDTH  synchronized (and filtered) level
rise_o  output  WIDTH  one-cycle pulse per channel on 0->1 of data_o
fall_o  output  WIDTH  one-cycle pulse per channel on 1->0 of data_o
change_o  output  WIDTH  rise_o | fall_o

Behaviour:
- Reset: aclk and arstn only; arstn is asynchronous and active-low, deasserted externally synchronized to aclk.
  - While arstn=0, every chain flop, filtered state and edge-history register = RST_VAL; counters = 0.
  - data_o = RST_VAL; rise_o, fall_o, change_o = 0.
  - Asserting arstn mid-operation (mid-count, mid-chain) takes effect immediately.
  - After release there is no edge pulse unless data_o later differs from RST_VAL.
- Sync chain, per bit, each aclk rising edge: stage[0] <= data_i; stage[k] <= stage[k-1]. s = stage[STAGES-1].
  - Latency from the edge that samples a new data_i to s: STAGES cycles.
- Filter, FILTER=0: data_o = s, combinationally from the last flop. No counters are instantiated.
- Filter, FILTER>=1: per-channel state f (drives data_o) and counter cnt, width max(1,$clog2(FILTER)).
  - Each edge: if s==f then cnt<=0.
  - Else if cnt==FILTER-1 then f<=s and cnt<=0.
  - Else cnt<=cnt+1.
  - A change of s is accepted after exactly FILTER consecutive cycles of s!=f. Input-to-data_o latency = STAGES+FILTER cycles.
  - Any return of s to f before acceptance clears cnt, so the pulse is rejected entirely and the count restarts on the next difference.
  - FILTER=1: one extra register cycle, no rejection.
- Edge detect: per channel, prev <= data_o each edge (reset RST_VAL).
  - rise_o = data_o & ~prev; fall_o = ~data_o & prev; change_o = rise_o | fall_o.
  - Each pulse is high exactly one cycle, the first cycle the new data_o level is visible.
  - rise_o and fall_o are never both high on one channel.
- Channels are fully independent: simultaneous changes on several bits are each filtered and timed separately. There is no bus coherency guarantee, so multi-bit values must not be passed through this block.
- No handshake; data_i has no timing relation to aclk. Input pulses shorter than one aclk period may be missed; this is by design.

Test Plan:
- WIDTH=4, STAGES=2, FILTER=3, RST_VAL=4'b0101; data_i=4'b0101 through reset, release arstn.
  - -> data_o=0101 during and after reset.
  - -> rise_o/fall_o/change_o=0 for 20 cycles.
- Same config; data_i[1] 0->1 sampled at edge 0 and held.
  - -> data_o[1]=1 from edge 5 on.
  - -> rise_o[1] and change_o[1] high during cycle 5 only; other bits unchanged.
- Same config; data_i[3] high for 2 cycles, then low.
  - -> data_o[3] stays 0; no rise_o/fall_o on bit 3.
- Same config; data_i[2] (reset 1) sequence low 2, high 1, low held.
  - -> data_o[2] falls only 3 cycles after s[2] goes low the second time.
  - -> single fall_o[2] pulse; no pulse from the first low burst.
- Instance WIDTH=2, STAGES=3, FILTER=0; data_i 00->11 at edge 0.
  - -> data_o=11 from edge 3.
  - -> rise_o=11 for one cycle.
  - -> with FILTER=0, a 1-cycle data_i pulse passes through (1-cycle data_o pulse, rise then fall).
- FILTER=3 config; data_i[0] 1->0 (reset 1), assert arstn at cnt=1, release 2 cycles later with data_i[0]=1.
  - -> data_o[0]=1 immediately at assertion.
  - -> no fall_o/rise_o before or after release.
